// File: rtl/note_judge.sv
`default_nettype none
// ============================================================================
// Module   : note_judge
// Purpose  : Judges keypresses against timed note windows; emits hit/perfect/
//            miss pulses and maintains saturating score, combo and max combo.
// Revision : 1.0 - initial release
// ============================================================================
module note_judge #(
  parameter int WINDOW      = 16,
  parameter int PERFECT_WIN = 4,
  parameter int SCORE_W     = 10,
  parameter int COMBO_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic               beat,
  input  logic               note_valid,
  input  logic               key_any,
  input  logic               equal,
  output logic               hit_pulse,
  output logic               perfect_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic               window_open
);

  localparam int c_CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WINDOW - 1);
  localparam logic [c_CNT_W-1:0] c_PERF = c_CNT_W'(PERFECT_WIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPEN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;

  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_open;
  logic               w_correct;
  logic               w_miss;
  logic               w_perf;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [COMBO_W-1:0] w_combo_nxt;

  always_comb begin
    w_open    = (r_state == S_OPEN);
    w_correct = w_open & key_any & equal;
    // Wrong key, timeout and an unanswered beat collision all count as a miss.
    w_miss    = w_open & ((key_any & ~equal) |
                          (~key_any & ((r_cnt == c_LAST) | beat)));
    w_perf    = w_correct & (r_cnt < c_PERF);

    // Perfect adds 2, good adds 1; the extra MSB flags an overflow to clamp.
    w_sum       = {1'b0, score} + {{(SCORE_W-1){1'b0}}, w_perf, ~w_perf};
    w_score_nxt = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
    w_combo_nxt = (combo == {COMBO_W{1'b1}}) ? combo : combo + COMBO_W'(1);

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (beat) begin
      // A new beat always wins the next state, even if the old note was judged.
      w_state_nxt = note_valid ? S_OPEN : S_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_open) begin
      if (w_correct || w_miss) begin
        w_state_nxt = S_DONE;
      end else begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      hit_pulse     <= 1'b0;
      perfect_pulse <= 1'b0;
      miss_pulse    <= 1'b0;
      score         <= '0;
      combo         <= '0;
      max_combo     <= '0;
      window_open   <= 1'b0;
    end else if (!game_en) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      hit_pulse     <= 1'b0;
      perfect_pulse <= 1'b0;
      miss_pulse    <= 1'b0;
      window_open   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      window_open   <= (w_state_nxt == S_OPEN);
      hit_pulse     <= w_correct;
      perfect_pulse <= w_perf;
      miss_pulse    <= w_miss;
      if (w_correct) begin
        score <= w_score_nxt;
        combo <= w_combo_nxt;
        if (w_combo_nxt > max_combo) begin
          max_combo <= w_combo_nxt;
        end
      end else if (w_miss) begin
        combo <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_judge
// Purpose  : Directed self-checking bench for note_judge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_judge;

  logic       clk = 1'b0;
  logic       rst, game_en, beat, note_valid, key_any, equal;
  logic       hit_pulse, perfect_pulse, miss_pulse, window_open;
  logic [9:0] score;
  logic [7:0] combo, max_combo;

  int n_cmp = 0;
  int n_err = 0;

  note_judge #(.WINDOW(16), .PERFECT_WIN(4), .SCORE_W(10), .COMBO_W(8)) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .beat(beat),
    .note_valid(note_valid), .key_any(key_any), .equal(equal),
    .hit_pulse(hit_pulse), .perfect_pulse(perfect_pulse),
    .miss_pulse(miss_pulse), .score(score), .combo(combo),
    .max_combo(max_combo), .window_open(window_open)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input logic b, input logic nv, input logic k, input logic e);
    beat = b; note_valid = nv; key_any = k; equal = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic h, input logic p, input logic m,
                         input int sc, input int co, input int mx, input logic wo);
    chk({tag, ".hit"},     32'(hit_pulse),     32'(h));
    chk({tag, ".perfect"}, 32'(perfect_pulse), 32'(p));
    chk({tag, ".miss"},    32'(miss_pulse),    32'(m));
    chk({tag, ".score"},   32'(score),         sc);
    chk({tag, ".combo"},   32'(combo),         co);
    chk({tag, ".max"},     32'(max_combo),     mx);
    chk({tag, ".wopen"},   32'(window_open),   32'(wo));
  endtask

  initial begin
    rst = 1'b1; game_en = 1'b1;
    beat = 1'b0; note_valid = 1'b0; key_any = 1'b0; equal = 1'b0;
    idle(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Reset in the middle of an open window discards the note.
    cyc(1, 1, 0, 0);
    chk("open_before_rst", 32'(window_open), 1);
    idle(2);
    rst = 1'b1;
    idle(2);
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      idle(1);
      chk("rst_no_judge.miss", 32'(miss_pulse), 0);
    end
    chk("rst_no_judge.wopen", 32'(window_open), 0);

    // Perfect hit at cnt=2
    cyc(1, 1, 0, 0);
    idle(2);
    cyc(0, 0, 1, 1);
    chk_all("perfect", 1, 1, 0, 2, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk_all("perfect_end", 0, 0, 0, 2, 1, 1, 0);

    // Good hit at cnt=10
    cyc(1, 1, 0, 0);
    idle(10);
    cyc(0, 0, 1, 1);
    chk_all("good", 1, 0, 0, 3, 2, 2, 0);
    idle(1);

    // Timeout miss at cnt=15
    cyc(1, 1, 0, 0);
    idle(15);
    chk_all("pre_timeout", 0, 0, 0, 3, 2, 2, 1);
    idle(1);
    chk_all("timeout", 0, 0, 1, 3, 0, 2, 0);
    idle(1);
    chk("timeout_end.miss", 32'(miss_pulse), 0);

    // Wrong key at cnt=1, later correct press ignored
    cyc(1, 1, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0);
    chk_all("wrong", 0, 0, 1, 3, 0, 2, 0);
    cyc(0, 0, 1, 1);
    chk_all("after_wrong", 0, 0, 0, 3, 0, 2, 0);
    idle(1);

    // Key held across the beat is judged at cnt=0
    cyc(1, 1, 1, 1);
    chk_all("held_open", 0, 0, 0, 3, 0, 2, 1);
    cyc(0, 0, 1, 1);
    chk_all("held_hit", 1, 1, 0, 5, 1, 2, 0);
    idle(1);

    // Beat collision at cnt=7 with no key: one miss, new window at cnt=0
    cyc(1, 1, 0, 0);
    idle(7);
    cyc(1, 1, 0, 0);
    chk_all("collide_miss", 0, 0, 1, 5, 0, 2, 1);
    idle(15);
    chk_all("collide_run", 0, 0, 0, 5, 0, 2, 1);
    idle(1);
    chk_all("collide_timeout", 0, 0, 1, 5, 0, 2, 0);

    // Beat together with a correct press
    cyc(1, 1, 0, 0);
    idle(1);
    cyc(1, 1, 1, 1);
    chk_all("collide_hit", 1, 1, 0, 7, 1, 2, 1);
    cyc(0, 0, 1, 1);
    chk_all("collide_next", 1, 1, 0, 9, 2, 2, 0);
    idle(1);

    // Rest note opens nothing
    cyc(1, 0, 0, 0);
    chk_all("rest", 0, 0, 0, 9, 2, 2, 0);
    cyc(0, 0, 1, 1);
    chk_all("rest_press", 0, 0, 0, 9, 2, 2, 0);
    idle(16);
    chk("rest_nomiss", 32'(miss_pulse), 0);

    // game_en low: beats ignored, counters hold
    game_en = 1'b0;
    cyc(1, 1, 0, 0);
    chk_all("dis_beat", 0, 0, 0, 9, 2, 2, 0);
    cyc(0, 0, 1, 1);
    chk_all("dis_press", 0, 0, 0, 9, 2, 2, 0);
    game_en = 1'b1;
    cyc(1, 1, 0, 0);
    chk("en_open", 32'(window_open), 1);
    game_en = 1'b0;
    idle(1);
    chk_all("dis_mid", 0, 0, 0, 9, 2, 2, 0);
    game_en = 1'b1;
    idle(16);
    chk_all("reen_idle", 0, 0, 0, 9, 2, 2, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    chk_all("reen_hit", 1, 1, 0, 11, 3, 3, 0);
    idle(1);

    // Perfect/good boundary: cnt=3 perfect, cnt=4 good
    cyc(1, 1, 0, 0);
    idle(3);
    cyc(0, 0, 1, 1);
    chk_all("cnt3", 1, 1, 0, 13, 4, 4, 0);
    idle(1);
    cyc(1, 1, 0, 0);
    idle(4);
    cyc(0, 0, 1, 1);
    chk_all("cnt4", 1, 0, 0, 14, 5, 5, 0);
    idle(1);

    // Preload to 1022 with perfect hits; combo saturates on the way
    for (int i = 0; i < 504; i++) begin
      cyc(1, 1, 1, 1);
      cyc(0, 0, 1, 1);
    end
    idle(1);
    chk_all("preload", 0, 0, 0, 1022, 255, 255, 0);
    cyc(1, 1, 1, 1);
    cyc(0, 0, 1, 1);
    chk_all("sat_perfect", 1, 1, 0, 1023, 255, 255, 0);
    cyc(1, 1, 1, 1);
    cyc(0, 0, 1, 1);
    chk_all("sat_hold", 1, 1, 0, 1023, 255, 255, 0);
    idle(1);
    cyc(1, 1, 0, 0);
    idle(5);
    cyc(0, 0, 1, 1);
    chk_all("sat_good", 1, 0, 0, 1023, 255, 255, 0);
    idle(1);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    chk_all("sat_miss", 0, 0, 1, 1023, 0, 255, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_judge.md
Name: note_judge

Overview:
- Scoring stage directly downstream of the 4-bit key/note comparator.
- Each note beat opens a timing window, and the block judges the player's keypress against the comparator's `equal` flag.
- Outputs perfect/hit/miss pulses plus running score, combo and max-combo counters for the display logic.
- All outputs registered; single clock domain.

Parameters:
- WINDOW, 16, length of the judgement window in clk cycles (≥2).
- PERFECT_WIN, 4, window cycles counted 0..PERFECT_WIN-1 that earn a perfect (< WINDOW).
- SCORE_W, 10, score counter width.
- COMBO_W, 8, combo and max_combo width.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- game_en, input, 1, gameplay enable; low forces IDLE and ignores beats, counters hold.
- beat, input, 1, one-cycle strobe when a new note becomes current.
- note_valid, input, 1, sampled with beat; 0 = rest note (nothing to judge).
- key_any, input, 1, any player key currently pressed (OR of the 4 key bits).
- equal, input, 1, comparator result: pressed keys match the current note.
- hit_pulse, output, 1, one-cycle pulse on any correct hit (perfect or good).
- perfect_pulse, output, 1, one-cycle pulse, asserted with hit_pulse for perfect hits only.
- miss_pulse, output, 1, one-cycle pulse on a miss.
- score, output, SCORE_W, accumulated points.
- combo, output, COMBO_W, consecutive hits.
- max_combo, output, COMBO_W, highest combo since reset.
- window_open, output, 1, high while in OPEN.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, window counter cnt=0, all pulses 0, score=0, combo=0, max_combo=0, window_open=0. Reset mid-window discards the pending note with no judgement.
- States:
  - IDLE: no note pending.
  - OPEN: window running.
  - DONE: current note already judged; awaiting next beat.
- Transitions with game_en=1:
  - IDLE/DONE with beat & note_valid: go to OPEN, cnt=0.
  - IDLE/DONE with beat & !note_valid: go to IDLE.
  - IDLE/DONE, key activity: ignored, no penalty.
  - OPEN, correct (key_any & equal): hit, go to DONE.
    - cnt < PERFECT_WIN: perfect, +2 points.
    - Otherwise: good, +1 point.
    - combo += 1.
  - OPEN, wrong (key_any & !equal): miss, combo=0, go to DONE.
  - OPEN, timeout (cnt==WINDOW-1 with no key_any): miss, combo=0, go to DONE.
  - OPEN, otherwise: cnt += 1.
- Priority in OPEN, same cycle: correct > wrong > timeout.
- beat while OPEN:
  - The current note is judged first using that cycle's inputs.
  - If neither correct nor wrong, it counts as a miss.
  - Then the next state follows the new beat's note_valid (OPEN with cnt=0, or IDLE).
  - Exactly one judgement pulse is produced.
- Latency: inputs sampled at edge N; pulses, score, combo and max_combo take new values after edge N, i.e. visible during cycle N+1. Pulses last exactly one cycle.
- window_open = (state==OPEN), registered with the state.
- Arithmetic:
  - score saturates at 2^SCORE_W-1; an add that would overflow clamps.
  - combo saturates at 2^COMBO_W-1.
  - On a hit, max_combo gets the new combo when new combo > max_combo, in the same cycle as the combo update.
- game_en=0: state forced to IDLE, cnt=0, no pulses, score/combo/max_combo hold. Re-enable resumes at the next beat.
- key_any held across windows: a key still held when a new window opens is judged on the window's first cycle (cnt=0). No edge detection in this block.

Test Plan:
- Reset: assert rst 2 cycles during OPEN → all outputs 0, state IDLE, no pulse on release.
- Perfect hit: beat with note_valid=1; key_any=equal=1 two cycles later (cnt=2) → perfect_pulse=hit_pulse=1 for one cycle, score=2, combo=1, max_combo=1, window_open falls.
- Good hit then miss:
  - Hit at cnt=10 → score=3, combo=2.
  - Next note gets no key for 16 cycles → miss_pulse at cnt=15, combo=0, max_combo=2, score unchanged.
- Wrong key: key_any=1, equal=0 at cnt=1 → miss_pulse, combo=0. A later correct press in the same window is ignored (state DONE).
- Beat collision: beat arrives at cnt=7 with no key → single miss_pulse, new window opens with cnt=0. Separately, beat and a correct press in the same cycle → hit credited and new window opened.
- Saturation and rest note:
  - Preload to score=1022, then a perfect hit → score=1023.
  - beat with note_valid=0 → no window, no pulse.
  - game_en=0 during a beat → ignored, counters held.
